// File: rtl/scan_buffer_ctrl_if.sv
// Bus bundle for scan_buffer_ctrl: sample/drain handshakes plus packed per-channel status.
// The slave modport is the controller side and the master modport is the driver/observer side.
interface scan_buffer_ctrl_if #(
    parameter int NCH = 2,
    parameter int CW  = 8,
    parameter int CHW = 1
);
    logic                  start_scan;
    logic                  sample_valid;
    logic                  transfer_req;
    logic                  drain_ready;
    logic [CHW-1:0]        active_ch;
    logic [3*NCH-1:0]      state;
    logic [CW*NCH-1:0]     count;
    logic [NCH-1:0]        ready_to_transfer;
    logic                  drain_valid;
    logic [CHW-1:0]        drain_ch;
    logic [NCH-1:0]        flush;
    logic                  overrun;

    modport master (
        output start_scan, sample_valid, transfer_req, drain_ready,
        input  active_ch, state, count, ready_to_transfer,
        input  drain_valid, drain_ch, flush, overrun
    );

    modport slave (
        input  start_scan, sample_valid, transfer_req, drain_ready,
        output active_ch, state, count, ready_to_transfer,
        output drain_valid, drain_ch, flush, overrun
    );
endinterface

// File: rtl/scan_buffer_ctrl.sv
// N-channel ping-pong scan buffer controller; stale-buffer reclaim under AUTO_FLUSH_EN.
// Latency: every output is registered, and reacts one cycle after the causing edge.
// Backpressure: drain advances only while drain_ready is high; samples that arrive with no channel in SCAN are dropped and pulse overrun.
module scan_buffer_ctrl #(
    parameter int NCH   = 2,
    parameter int DEPTH = 100,
    parameter int CW    = 8,
    parameter int CHW   = 1
) (
    input  logic            clk,
    input  logic            rst,
    scan_buffer_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        FULL  = 3'd2,
        XFER  = 3'd3,
        FLUSH = 3'd4
    } ch_state_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] HALF_C  = CW'(DEPTH / 2);

    ch_state_t       st_q  [NCH];
    ch_state_t       st_d  [NCH];
    logic [CW-1:0]   cnt_q [NCH];
    logic [CW-1:0]   cnt_d [NCH];
    logic [CHW-1:0]  act_q, act_d;
    logic            started_q, started_d;
    logic [NCH-1:0]  rtt_q, rtt_d;
    logic [NCH-1:0]  flush_q, flush_d;
    logic            ovr_q, ovr_d;
    logic            dv_q, dv_d;
    logic [CHW-1:0]  dch_q, dch_d;

    logic            all_idle, any_xfer, scan_on;
    logic [CHW-1:0]  nxt, idx, sel;
    logic            sel_vld, fl_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i]  <= IDLE;
                cnt_q[i] <= '0;
            end
            act_q     <= '0;
            started_q <= 1'b0;
            rtt_q     <= '0;
            flush_q   <= '0;
            ovr_q     <= 1'b0;
            dv_q      <= 1'b0;
            dch_q     <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            act_q     <= act_d;
            started_q <= started_d;
            rtt_q     <= rtt_d;
            flush_q   <= flush_d;
            ovr_q     <= ovr_d;
            dv_q      <= dv_d;
            dch_q     <= dch_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
        end
        act_d     = act_q;
        started_d = started_q;
        flush_d   = '0;
        ovr_d     = 1'b0;
        rtt_d     = '0;
        dv_d      = 1'b0;
        dch_d     = '0;
        idx       = '0;
        sel       = '0;
        sel_vld   = 1'b0;
        fl_done   = 1'b0;
        all_idle  = 1'b1;
        any_xfer  = 1'b0;

        for (int i = 0; i < NCH; i++) begin
            if (st_q[i] != IDLE) all_idle = 1'b0;
            if (st_q[i] == XFER) any_xfer = 1'b1;
        end
        // The SCAN channel, when there is one, is always active_ch.
        scan_on = (st_q[act_q] == SCAN);
        nxt     = (act_q == CHW'(NCH - 1)) ? '0 : act_q + 1'b1;

        if (bus.start_scan && all_idle) begin
            st_d[act_q]  = SCAN;
            cnt_d[act_q] = '0;
            started_d    = 1'b1;
        end else if (scan_on) begin
            if (bus.sample_valid && cnt_q[act_q] != DEPTH_C) begin
                cnt_d[act_q] = cnt_q[act_q] + 1'b1;
                if (cnt_q[act_q] == LAST_C) begin
                    st_d[act_q] = FULL;
                    if (st_q[nxt] == IDLE) begin
                        st_d[nxt]  = SCAN;
                        cnt_d[nxt] = '0;
                        act_d      = nxt;
                    end
                end
            end
        end else if (started_q) begin
            ovr_d = bus.sample_valid;
            if (st_q[nxt] == IDLE) begin
                st_d[nxt]  = SCAN;
                cnt_d[nxt] = '0;
                act_d      = nxt;
            end
        end

        for (int i = 0; i < NCH; i++) begin
            if (st_q[i] == XFER && bus.drain_ready && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
                if (cnt_q[i] == CW'(1)) st_d[i] = IDLE;
            end
            if (st_q[i] == FLUSH) st_d[i] = IDLE;
        end

        // Oldest first: search upward from the channel after active_ch.
        if (bus.transfer_req && !any_xfer) begin
            for (int k = 1; k <= NCH; k++) begin
                idx = CHW'((int'(act_q) + k) % NCH);
                if (!sel_vld && st_q[idx] == FULL) begin
                    sel     = idx;
                    sel_vld = 1'b1;
                end
            end
            if (sel_vld) st_d[sel] = XFER;
        end

`ifdef AUTO_FLUSH_EN
        if (scan_on && cnt_q[act_q] >= HALF_C) begin
            for (int i = 0; i < NCH; i++) begin
                if (!fl_done && st_q[i] == FULL && !(sel_vld && sel == CHW'(i))) begin
                    st_d[i]    = FLUSH;
                    cnt_d[i]   = '0;
                    flush_d[i] = 1'b1;
                    fl_done    = 1'b1;
                end
            end
        end
`else
        fl_done = (HALF_C == '0) && 1'b0;
`endif

        for (int i = 0; i < NCH; i++) begin
            rtt_d[i] = (st_d[i] == FULL);
            if (st_d[i] == XFER) begin
                dv_d  = 1'b1;
                dch_d = CHW'(i);
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign bus.state[3*g +: 3]  = st_q[g];
        assign bus.count[CW*g +: CW] = cnt_q[g];
    end

    assign bus.active_ch         = act_q;
    assign bus.ready_to_transfer = rtt_q;
    assign bus.flush             = flush_q;
    assign bus.overrun           = ovr_q;
    assign bus.drain_valid       = dv_q;
    assign bus.drain_ch          = dch_q;
endmodule

// File: tb/tb_scan_buffer_ctrl.sv
// Directed bench for scan_buffer_ctrl (NCH=2, DEPTH=4); AUTO_FLUSH_EN selects the flush scenario instead of the overrun one.
module tb_scan_buffer_ctrl;
    localparam int NCH = 2, DEPTH = 4, CW = 3, CHW = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ovr_seen;

    scan_buffer_ctrl_if #(.NCH(NCH), .CW(CW), .CHW(CHW)) bus ();

    scan_buffer_ctrl #(.NCH(NCH), .DEPTH(DEPTH), .CW(CW), .CHW(CHW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},  32'(bus.state), 32'h0);
        check({tag, "_count"},  32'(bus.count), 32'h0);
        check({tag, "_active"}, 32'(bus.active_ch), 32'h0);
        check({tag, "_rtt"},    32'(bus.ready_to_transfer), 32'h0);
        check({tag, "_dv"},     32'(bus.drain_valid), 32'h0);
        check({tag, "_dch"},    32'(bus.drain_ch), 32'h0);
        check({tag, "_flush"},  32'(bus.flush), 32'h0);
        check({tag, "_ovr"},    32'(bus.overrun), 32'h0);
    endtask

    initial begin
        bus.start_scan   = 1'b0;
        bus.sample_valid = 1'b0;
        bus.transfer_req = 1'b0;
        bus.drain_ready  = 1'b0;

        // Reset held for two cycles.
        step();
        step();
        check_reset("rst");
        rst = 1'b0;
        step();

        // Start and fill ch0; handoff to ch1.
        bus.start_scan = 1'b1;
        step();
        bus.start_scan = 1'b0;
        check("start_state", 32'(bus.state), 32'h01);
        bus.sample_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("fill_cnt", 32'(bus.count[2:0]), 32'(k));
        end
        step();
        bus.sample_valid = 1'b0;
        check("fill_state",  32'(bus.state), 32'h0A);
        check("fill_rtt",    32'(bus.ready_to_transfer), 32'h1);
        check("fill_active", 32'(bus.active_ch), 32'h1);
        check("fill_count",  32'(bus.count), 32'h04);

        // Drain ch0.
        bus.transfer_req = 1'b1;
        bus.drain_ready  = 1'b1;
        step();
        bus.transfer_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("drain_dv",  32'(bus.drain_valid), 32'h1);
            check("drain_dch", 32'(bus.drain_ch), 32'h0);
            check("drain_cnt", 32'(bus.count[2:0]), 32'(4 - k));
            step();
        end
        check("drain_done_dv",    32'(bus.drain_valid), 32'h0);
        check("drain_done_state", 32'(bus.state), 32'h08);
        check("drain_done_cnt",   32'(bus.count[2:0]), 32'h0);

`ifdef AUTO_FLUSH_EN
        // ch1 full, ch0 scanning reaches DEPTH/2 -> ch1 flushed.
        bus.sample_valid = 1'b1;
        repeat (6) step();
        bus.sample_valid = 1'b0;
        check("af_pre_state", 32'(bus.state), 32'h11);
        check("af_pre_flush", 32'(bus.flush), 32'h0);
        step();
        check("af_state", 32'(bus.state), 32'h21);
        check("af_flush", 32'(bus.flush), 32'h2);
        check("af_cnt1",  32'(bus.count[5:3]), 32'h0);
        step();
        check("af_idle_state", 32'(bus.state), 32'h01);
        check("af_idle_flush", 32'(bus.flush), 32'h0);
        // Finish ch0, push ch1 to DEPTH/2, then request transfer in the flush-eligible cycle.
        bus.sample_valid = 1'b1;
        repeat (4) step();
        bus.sample_valid = 1'b0;
        check("cf_pre_cnt1", 32'(bus.count[5:3]), 32'h2);
        bus.transfer_req = 1'b1;
        step();
        bus.transfer_req = 1'b0;
        check("cf_state", 32'(bus.state), 32'h0B);
        check("cf_flush", 32'(bus.flush), 32'h0);
        check("cf_dv",    32'(bus.drain_valid), 32'h1);
        check("cf_dch",   32'(bus.drain_ch), 32'h0);
`else
        // Fill both channels with no transfer, then overrun three times.
        bus.sample_valid = 1'b1;
        repeat (4) step();
        check("ov_mid_state",  32'(bus.state), 32'h11);
        check("ov_mid_active", 32'(bus.active_ch), 32'h0);
        repeat (4) step();
        check("ov_full_state",  32'(bus.state), 32'h12);
        check("ov_full_rtt",    32'(bus.ready_to_transfer), 32'h3);
        check("ov_full_active", 32'(bus.active_ch), 32'h0);
        ovr_seen = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("ov_pulse", 32'(bus.overrun), 32'h1);
            if (bus.overrun) ovr_seen++;
        end
        bus.sample_valid = 1'b0;
        step();
        check("ov_total",     32'(ovr_seen), 32'h3);
        check("ov_end",       32'(bus.overrun), 32'h0);
        check("ov_end_state", 32'(bus.state), 32'h12);
        check("ov_end_count", 32'(bus.count), 32'h24);
        check("ov_end_flush", 32'(bus.flush), 32'h0);
        // Oldest-first selection: ch1 filled first; request held to chain.
        bus.transfer_req = 1'b1;
        step();
        check("sel_state", 32'(bus.state), 32'h1A);
        check("sel_dch",   32'(bus.drain_ch), 32'h1);
        check("sel_dv",    32'(bus.drain_valid), 32'h1);
        repeat (4) step();
        check("chain_gap_state", 32'(bus.state), 32'h02);
        check("chain_gap_dv",    32'(bus.drain_valid), 32'h0);
        step();
        bus.transfer_req = 1'b0;
        check("chain_state",  32'(bus.state), 32'h0B);
        check("chain_active", 32'(bus.active_ch), 32'h1);
        check("chain_dch",    32'(bus.drain_ch), 32'h0);
        check("chain_dv",     32'(bus.drain_valid), 32'h1);
`endif

        // Reset mid-drain, asynchronously.
        step();
        check("mid_cnt0", 32'(bus.count[2:0]), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        check_reset("arst");
        step();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
